// File: rtl/controle_lampada.sv
// -----------------------------------------------------------------------------
// controle_lampada
//
// Lamp controller for the automatic-lighting subsystem. It debounces the wall
// push button, classifies each completed press as short or long, and runs the
// AUTO/MANUAL lamp state machine. In AUTO mode presence turns the lamp on and
// the shutdown timer's pulse turns it off. In MANUAL mode short presses
// toggle the lamp. A long press always swaps between AUTO and MANUAL.
//
// There is no valid/ready handshake on this block. All inputs are level or
// single-cycle pulse signals sampled on every rising clock edge.
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous reset, active low
//   push_button    raw bouncing button level, 1 = pressed
//   infravermelho  presence sensor, 1 = presence
//   C              one-cycle shutdown pulse from the auto-shutdown timer
//   L              lamp drive, 1 = on
//   H              shutdown timer enable, 1 only in AUTO_ON
//   M              mode indicator, 1 = MANUAL
//   o_state        debug view of the FSM state register
// -----------------------------------------------------------------------------
module controle_lampada #(
    parameter int unsigned DEBOUNCE_T   = 50,
    parameter int unsigned LONG_PRESS_T = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_button,
    input  logic       infravermelho,
    input  logic       C,
    output logic       L,
    output logic       H,
    output logic       M,
    output logic [1:0] o_state
);

    typedef enum logic [1:0] {
        AUTO_OFF   = 2'b00,
        AUTO_ON    = 2'b01,
        MANUAL_OFF = 2'b10,
        MANUAL_ON  = 2'b11
    } state_t;

    localparam logic [15:0] DB_LAST  = 16'(DEBOUNCE_T - 1);
    localparam logic [15:0] LONG_LIM = 16'(LONG_PRESS_T);

    logic [15:0] r_cnt_db;
    logic        r_btn_db;
    logic        r_btn_db_q;
    logic [15:0] r_cnt_press;
    logic        r_short_ev;
    logic        r_long_ev;
    state_t      r_state;
    state_t      w_state_next;
    logic        w_release;

    // Debouncer: the raw level has to differ from the accepted level for
    // DEBOUNCE_T consecutive cycles before it is accepted. Any cycle where the
    // raw level agrees again restarts the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt_db <= 16'd0;
            r_btn_db <= 1'b0;
        end else if (push_button != r_btn_db) begin
            if (r_cnt_db == DB_LAST) begin
                r_btn_db <= push_button;
                r_cnt_db <= 16'd0;
            end else begin
                r_cnt_db <= r_cnt_db + 16'd1;
            end
        end else begin
            r_cnt_db <= 16'd0;
        end
    end

    assign w_release = r_btn_db_q && !r_btn_db;

    // Press classifier. The counter saturates so a very long hold cannot wrap
    // back into the short range. The event is only decided on release, so a
    // held button produces nothing until it is let go.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_btn_db_q  <= 1'b0;
            r_cnt_press <= 16'd0;
            r_short_ev  <= 1'b0;
            r_long_ev   <= 1'b0;
        end else begin
            r_btn_db_q <= r_btn_db;
            r_short_ev <= 1'b0;
            r_long_ev  <= 1'b0;
            if (w_release) begin
                r_cnt_press <= 16'd0;
                if (r_cnt_press >= LONG_LIM) begin
                    r_long_ev <= 1'b1;
                end else begin
                    r_short_ev <= 1'b1;
                end
            end else if (r_btn_db && (r_cnt_press < LONG_LIM)) begin
                r_cnt_press <= r_cnt_press + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= AUTO_OFF;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state. long_ev has top priority in every state; C and presence only
    // matter in the AUTO states.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            AUTO_OFF: begin
                if (r_long_ev) begin
                    w_state_next = MANUAL_OFF;
                end else if (infravermelho) begin
                    w_state_next = AUTO_ON;
                end
            end
            AUTO_ON: begin
                if (r_long_ev) begin
                    w_state_next = MANUAL_OFF;
                end else if (C) begin
                    w_state_next = AUTO_OFF;
                end
            end
            MANUAL_OFF: begin
                if (r_long_ev) begin
                    w_state_next = AUTO_OFF;
                end else if (r_short_ev) begin
                    w_state_next = MANUAL_ON;
                end
            end
            MANUAL_ON: begin
                if (r_long_ev) begin
                    w_state_next = AUTO_OFF;
                end else if (r_short_ev) begin
                    w_state_next = MANUAL_OFF;
                end
            end
            default: w_state_next = AUTO_OFF;
        endcase
    end

    assign L       = (r_state == AUTO_ON) || (r_state == MANUAL_ON);
    assign H       = (r_state == AUTO_ON);
    assign M       = (r_state == MANUAL_OFF) || (r_state == MANUAL_ON);
    assign o_state = r_state;

endmodule

// File: doc/controle_lampada.md
# controle_lampada

Lamp controller for the automatic-lighting subsystem: debounces the wall push button, classifies presses as short or long, and runs the AUTO/MANUAL lamp state machine. It drives the shutdown timer's `enable` and consumes its one-cycle `C` shutdown pulse. In AUTO mode, presence turns the lamp on and `C` turns it off. In MANUAL mode, short presses toggle the lamp.

## Interface
- `DEBOUNCE_T`, default 50: consecutive stable cycles needed to accept a button level change; range 1..65535.
- `LONG_PRESS_T`, default 5000: minimum debounced-pressed cycles for a long press; range 1..65535.
- `clk` input 1: single system clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-low reset. Low clears all state immediately.
- `push_button` input 1: raw, bouncing button level; 1 = pressed.
- `infravermelho` input 1: presence sensor; 1 = presence detected.
- `C` input 1: shutdown pulse from the auto-shutdown timer; one cycle wide.
- `L` output 1: lamp drive; 1 = lamp on.
- `H` output 1: enable to the shutdown timer; 1 only in AUTO_ON.
- `M` output 1: mode indicator; 1 = MANUAL mode.

## Operation
- Debouncer: 16-bit counter `cnt_db` and registered level `btn_db`.
  - When `push_button != btn_db`: if `cnt_db == DEBOUNCE_T-1`, then `btn_db <= push_button` and `cnt_db <= 0`; otherwise `cnt_db++`.
  - When `push_button == btn_db`: `cnt_db <= 0`.
  - A bounce shorter than `DEBOUNCE_T` cycles never changes `btn_db`.
- Press classifier: 16-bit `cnt_press` and a registered copy `btn_db_q`.
  - While `btn_db == 1`: `cnt_press` increments, saturating at `LONG_PRESS_T`. It never wraps.
  - On the falling edge (`btn_db_q == 1 && btn_db == 0`), register exactly one event for one cycle and clear `cnt_press`:
    - `long_ev` if `cnt_press >= LONG_PRESS_T`;
    - `short_ev` otherwise.
  - A press fires no event until it is released.
- FSM states: AUTO_OFF, AUTO_ON, MANUAL_OFF, MANUAL_ON. Reset state is AUTO_OFF.
  - AUTO_OFF: `long_ev` -> MANUAL_OFF; else `infravermelho` -> AUTO_ON; else stay. `short_ev` is ignored.
  - AUTO_ON: `long_ev` -> MANUAL_OFF; else `C` -> AUTO_OFF; else stay. `short_ev` and `infravermelho` are ignored; timer restart is the timer's job.
  - MANUAL_OFF: `long_ev` -> AUTO_OFF; `short_ev` -> MANUAL_ON; else stay.
  - MANUAL_ON: `long_ev` -> AUTO_OFF; `short_ev` -> MANUAL_OFF; else stay.
  - Illegal encoding -> AUTO_OFF.
- Priority: `long_ev` > `C` > `infravermelho`. `C` and `infravermelho` are ignored in MANUAL states.
- Outputs are Moore, decoded from the state register:
  - `L` = AUTO_ON or MANUAL_ON;
  - `H` = AUTO_ON;
  - `M` = MANUAL_OFF or MANUAL_ON.

## Timing
- Reset values while `rst` is low:
  - outputs `L=0`, `H=0`, `M=0`;
  - internal `btn_db=0`, `btn_db_q=0`, `cnt_db=0`, `cnt_press=0`, no event, state AUTO_OFF.
- After `rst` rises, the first rising clock edge is a normal operating edge.
- Reset mid-press: the press is discarded. A button still held after reset must first debounce to 1 and then be released before any event fires.
- Button latency, counting from the first cycle `push_button` differs stably (edge 1):
  - `btn_db` changes after edge `DEBOUNCE_T`;
  - the event is high after edge `DEBOUNCE_T+1`;
  - state and outputs change after edge `DEBOUNCE_T+2`.
- Presence latency: `infravermelho` high at edge k in AUTO_OFF gives `L=1` and `H=1` after edge k.
- `C` latency: `C` high at edge k in AUTO_ON gives `L=0` and `H=0` after edge k.
- Press length is the number of cycles `btn_db` was 1. Exactly `LONG_PRESS_T` cycles counts as long; `LONG_PRESS_T-1` counts as short.
- Events are single-cycle. A held button cannot generate repeated events.

## Test plan
Bench parameters: `DEBOUNCE_T=4`, `LONG_PRESS_T=20`.
- Reset and presence: hold `rst=0` for 3 cycles, check `L/H/M=0`. Release `rst`, pulse `infravermelho` for 1 cycle -> `L=1`, `H=1`, `M=0` after that edge. Pulse `C` -> `L=0`, `H=0` after that edge.
- Bounce rejection: toggle `push_button` 1,0,1,0 with runs of 3 cycles each -> `btn_db` stays 0, no event, state unchanged for 30 cycles.
- Short press: in MANUAL_OFF, hold `push_button=1` for 10 cycles, then release -> `L=1` exactly 6 cycles after the release (`DEBOUNCE_T+2`), `M` stays 1.
- Long press boundary: from AUTO_OFF, a press giving exactly 20 debounced cycles -> MANUAL_OFF (`M=1`, `L=0`). Repeat with 19 debounced cycles -> short event, AUTO_OFF stays unchanged.
- Priority: in AUTO_ON, assert `C` in the same cycle `long_ev` fires -> MANUAL_OFF, not AUTO_OFF. In MANUAL_ON, assert `C` and `infravermelho` for 5 cycles -> `L` stays 1, `H` stays 0.
- Reset mid-press: assert `rst=0` while a press has run 15 debounced cycles, release `rst` with the button still held, then release the button at 8 debounced cycles -> a short event only, starting from AUTO_OFF (ignored, `L=0`).
